// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - in-flight write scoreboard with stall/forward select for the MIPS pipeline
module pipe_scoreboard #(
    parameter int NREG   = 32,
    parameter int RW     = 5,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1,
    parameter int SW     = 2,
    parameter int CW     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wr_en,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_is_load,
    input  logic            flush,
    output logic            stall,
    output logic [SW-1:0]   fwd_rs,
    output logic [SW-1:0]   fwd_rt,
    output logic [NREG-1:0] busy,
    output logic [CW-1:0]   stall_cnt
);

    // slot 0 = EX, slot DEPTH-1 = WB
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_load;
    logic [RW-1:0]    slot_rd [DEPTH];

    logic [DEPTH-1:0] nxt_valid;
    logic [DEPTH-1:0] nxt_load;
    logic [RW-1:0]    nxt_rd [DEPTH];
    logic [NREG-1:0]  nxt_busy;

    logic             issue;
    logic [SW:0]      rs_res;
    logic [SW:0]      rt_res;

    // Youngest-writer lookup for one source; returns {stall_request, forward_select}
    function automatic logic [SW:0] lookup(input logic use_r, input logic [RW-1:0] r);
        logic          hit;
        int            idx;
        logic          st;
        logic [SW-1:0] f;
        hit = 1'b0;
        idx = 0;
        // Scan oldest to youngest so the lowest matching slot wins
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_r && (r != '0) && slot_valid[k] && (slot_rd[k] == r)) begin
                hit = 1'b1;
                idx = k;
            end
        end
        if (FWD_EN != 0) begin
            st = hit && (idx == 0) && slot_load[0];
            f  = hit ? SW'(idx + 1) : '0;
        end else begin
            st = hit;
            f  = '0;
        end
        return {st, f};
    endfunction

    // Hazard decision for both decode sources; zero while reset is held
    always_comb begin
        rs_res = lookup(id_use_rs, id_rs);
        rt_res = lookup(id_use_rt, id_rt);
        stall  = rst && id_valid && !flush && (rs_res[SW] || rt_res[SW]);
        fwd_rs = rst ? rs_res[SW-1:0] : '0;
        fwd_rt = rst ? rt_res[SW-1:0] : '0;
        issue  = id_valid && !stall && !flush && id_wr_en && (id_rd != '0);
    end

    // Next slot contents: shift toward WB, squash ID/EX on flush, derive busy bitmap
    always_comb begin
        nxt_valid[0] = issue;
        nxt_rd[0]    = id_rd;
        nxt_load[0]  = id_is_load;
        for (int k = 1; k < DEPTH; k++) begin
            nxt_valid[k] = slot_valid[k-1] && !(flush && (k == 1));
            nxt_rd[k]    = slot_rd[k-1];
            nxt_load[k]  = slot_load[k-1];
        end
        nxt_busy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            for (int r = 1; r < NREG; r++) begin
                if (nxt_valid[k] && (nxt_rd[k] == RW'(r))) begin
                    nxt_busy[r] = 1'b1;
                end
            end
        end
    end

    // Slot shift register, busy bitmap and saturating stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid <= '0;
            slot_load  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_rd[k] <= '0;
            end
            busy      <= '0;
            stall_cnt <= '0;
        end else begin
            slot_valid <= nxt_valid;
            slot_load  <= nxt_load;
            for (int k = 0; k < DEPTH; k++) begin
                slot_rd[k] <= nxt_rd[k];
            end
            busy <= nxt_busy;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb/tb_pipe_scoreboard.sv - directed self-checking bench for pipe_scoreboard
module tb_pipe_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_wr_en;
    logic [4:0]  id_rd;
    logic        id_is_load;
    logic        flush;

    logic        f_stall, n_stall, s_stall;
    logic [1:0]  f_fwd_rs, f_fwd_rt, n_fwd_rs, n_fwd_rt, s_fwd_rs, s_fwd_rt;
    logic [31:0] f_busy, n_busy, s_busy;
    logic [31:0] f_cnt, n_cnt;
    logic [3:0]  s_cnt;

    int n_checks;
    int n_fail;

    pipe_scoreboard #(.FWD_EN(1)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .stall(f_stall), .fwd_rs(f_fwd_rs),
        .fwd_rt(f_fwd_rt), .busy(f_busy), .stall_cnt(f_cnt)
    );

    pipe_scoreboard #(.FWD_EN(0)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .stall(n_stall), .fwd_rs(n_fwd_rs),
        .fwd_rt(n_fwd_rt), .busy(n_busy), .stall_cnt(n_cnt)
    );

    pipe_scoreboard #(.FWD_EN(1), .CW(4)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .stall(s_stall), .fwd_rs(s_fwd_rs),
        .fwd_rt(s_fwd_rt), .busy(s_busy), .stall_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic we,
                         input logic [4:0] rd, input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_wr_en   = we;
        id_rd      = rd;
        id_is_load = ld;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        flush = 1'b0;
        idle();
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        flush    = 1'b0;
        idle();

        // 1: reset with random inputs, then back-to-back ALU dependency
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 5'($urandom), 1'($urandom));
            flush = 1'($urandom);
            tick();
        end
        #1;
        check("rst_busy", f_busy, 32'h0);
        check("rst_cnt", f_cnt, 32'h0);
        check("rst_stall", {31'b0, f_stall}, 32'h0);
        flush = 1'b0;
        rst   = 1'b1;
        drive(1, 1, 2, 1, 1, 1, 3, 0);
        check("alu1_stall", {31'b0, f_stall}, 32'h0);
        tick();
        check("busy3_c1", {31'b0, f_busy[3]}, 32'h1);
        drive(1, 3, 3, 1, 1, 1, 4, 0);
        check("alu2_fwd_rs", {30'b0, f_fwd_rs}, 32'h1);
        check("alu2_fwd_rt", {30'b0, f_fwd_rt}, 32'h1);
        check("alu2_stall", {31'b0, f_stall}, 32'h0);
        tick();
        check("busy3_c2", {31'b0, f_busy[3]}, 32'h1);
        idle();
        tick();
        check("busy3_c3", {31'b0, f_busy[3]}, 32'h1);
        tick();
        check("busy3_gone", {31'b0, f_busy[3]}, 32'h0);

        // 2: load-use
        do_reset();
        drive(1, 1, 0, 1, 0, 1, 5, 1);
        tick();
        drive(0, 5, 0, 1, 1, 1, 6, 0);
        check("lu_invalid_nostall", {31'b0, f_stall}, 32'h0);
        drive(1, 5, 0, 1, 1, 1, 6, 0);
        check("lu_stall", {31'b0, f_stall}, 32'h1);
        tick();
        check("lu_stall_end", {31'b0, f_stall}, 32'h0);
        check("lu_fwd_rs", {30'b0, f_fwd_rs}, 32'h2);
        check("lu_fwd_rt", {30'b0, f_fwd_rt}, 32'h0);
        check("lu_cnt", f_cnt, 32'h1);
        tick();

        // 3: stall-only mode
        do_reset();
        drive(1, 0, 0, 1, 0, 1, 7, 0);
        tick();
        drive(1, 7, 7, 1, 1, 1, 8, 0);
        check("nf_stall1", {31'b0, n_stall}, 32'h1);
        tick();
        check("nf_stall2", {31'b0, n_stall}, 32'h1);
        tick();
        check("nf_stall3", {31'b0, n_stall}, 32'h1);
        tick();
        check("nf_stall_end", {31'b0, n_stall}, 32'h0);
        check("nf_fwd_rs", {30'b0, n_fwd_rs}, 32'h0);
        check("nf_fwd_rt", {30'b0, n_fwd_rt}, 32'h0);
        check("nf_cnt", n_cnt, 32'h3);
        tick();

        // 4: r0 never tracked, youngest writer wins, WB slot forwards with DEPTH
        do_reset();
        drive(1, 1, 0, 1, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 1, 1, 0, 0, 0);
        check("r0_stall", {31'b0, f_stall}, 32'h0);
        check("r0_fwd", {30'b0, f_fwd_rs}, 32'h0);
        check("r0_busy", f_busy, 32'h0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 9, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 9, 0);
        tick();
        drive(1, 9, 9, 1, 0, 0, 0, 0);
        check("yw_fwd1", {30'b0, f_fwd_rs}, 32'h1);
        check("yw_rt_unused", {30'b0, f_fwd_rt}, 32'h0);
        tick();
        check("yw_fwd2", {30'b0, f_fwd_rs}, 32'h2);
        tick();
        check("yw_fwd_wb", {30'b0, f_fwd_rs}, 32'h3);
        tick();
        check("yw_fwd_none", {30'b0, f_fwd_rs}, 32'h0);

        // 5: flush squashes EX and ID
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 2, 1);
        tick();
        flush = 1'b1;
        drive(1, 2, 0, 1, 0, 1, 11, 0);
        check("fl_stall", {31'b0, f_stall}, 32'h0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_busy", f_busy, 32'h0);
        check("fl_no_stall", {31'b0, f_stall}, 32'h0);
        check("fl_fwd", {30'b0, f_fwd_rs}, 32'h0);
        check("fl_cnt", f_cnt, 32'h0);
        idle();
        tick();

        // 6: counter saturation and asynchronous reset mid-stall
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0, 1, 5, 1);
            tick();
            drive(1, 5, 0, 1, 0, 0, 0, 0);
            tick();
        end
        check("sat_cnt", {28'b0, s_cnt}, 32'hF);
        drive(1, 0, 0, 0, 0, 1, 5, 1);
        tick();
        drive(1, 5, 0, 1, 0, 0, 0, 0);
        check("sat_stall", {31'b0, s_stall}, 32'h1);
        check("sat_busy5", {31'b0, s_busy[5]}, 32'h1);
        rst = 1'b0;
        #1;
        check("arst_stall", {31'b0, s_stall}, 32'h0);
        check("arst_cnt", {28'b0, s_cnt}, 32'h0);
        check("arst_busy", s_busy, 32'h0);
        check("arst_fwd", {30'b0, s_fwd_rs}, 32'h0);
        idle();
        tick();
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
